vcve2_vrf_mem_responder: RTL
============================

# vcve2_vrf_mem_responder

Memory-side responder for the vector register file data port. It answers the req/gnt/rvalid transactions issued by the VRF interface FSM, and backs them with a word-organised register array holding all vector registers. The block sits between the VRF interface's data memory port and the storage. It provides single-outstanding, fixed-latency reads and writes with byte enables and address-range error reporting.

## Interface
- VLEN, 128: bits per vector register.
- NumVregs, 32: number of vector registers.
- DataWidth, 32: word width; fixed at 32.
- AddrWidth, 32: byte-address width of data_addr_i.
- WaitCycles, 2: extra response latency, in cycles; honoured only with the configuration macro defined.
- Derived: Depth = NumVregs*VLEN/DataWidth (128 words); IdxW = $clog2(Depth).
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- data_req_i  in  1  request valid.
- data_gnt_o  out  1  request accepted this cycle.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  4  byte enables; used for writes only.
- data_addr_i  in  AddrWidth  byte address.
- data_wdata_i  in  32  write data.
- data_rvalid_o  out  1  response valid, one cycle per accepted request.
- data_rdata_o  out  32  read data; 0 for writes and errors.
- data_err_o  out  1  error flag; qualified by data_rvalid_o.

## Operation
- Word index = data_addr_i[2 +: IdxW].
- Error condition: data_addr_i[1:0] != 0, or data_addr_i >= Depth*4.
- Accept: data_gnt_o = data_req_i && (state allows). Request fields are sampled only in a grant cycle.
- Write (granted, no error):
  - mem[idx] byte b <= data_wdata_i byte b for each set data_be_i[b], at the end of the grant cycle.
  - be = 0: storage unchanged; normal response still given.
- Read (granted, no error): mem[idx] is captured into the response register at the end of the grant cycle.
- Error (read or write): storage untouched; response has data_err_o = 1 and data_rdata_o = 0.
- At most one transaction is outstanding.
- Exactly one rvalid pulse is returned per grant, in grant order.
- FSM states:
  - IDLE:
    - grant possible.
    - On grant with wait = 0 -> RESP.
    - On grant with wait > 0 -> WAIT, with cnt = WaitCycles - 1.
  - WAIT:
    - gnt = 0.
    - cnt decrements each cycle.
    - cnt == 0 -> RESP.
  - RESP:
    - rvalid = 1.
    - Grant is also possible in this cycle, so back-to-back requests are accepted.
    - Next state follows the IDLE rules for the new request; with no request -> IDLE.
- Wait counter width: $clog2(WaitCycles+1). It must not underflow.
- Storage array resets to all zeros. The response register and FSM reset too.

## Timing
- Reset values:
  - data_gnt_o = 0 (combinational; req is ignored during reset).
  - data_rvalid_o = 0, data_err_o = 0, data_rdata_o = 0.
  - state = IDLE.
- Base latency: a request granted in cycle T has its rvalid/rdata/err in cycle T+1+W.
  - W = 0 without the macro; W = WaitCycles with it.
- Throughput:
  - W = 0: one transaction per cycle, e.g. sustained READ1 -> READ2 -> WRITE sequences.
  - W > 0: one transaction per W+1 cycles.
- Read-after-write: a read granted at T+1 after a write granted at T returns the new data.
- Write and read to the same word granted in the same cycle cannot occur (single port).
- data_req_i may drop without a grant; no state change results.
- data_rvalid_o is never asserted without a prior grant.
- Reset mid-transaction: the pending response is dropped, no rvalid is produced, and the array is cleared.

## Configuration
- VCVE2_VRF_RESP_WAIT_EN defined: the WaitCycles wait states are inserted via the WAIT state, and gnt is held low during them.
- VCVE2_VRF_RESP_WAIT_EN undefined:
  - WaitCycles is ignored.
  - WAIT state and counter are not built.
  - Response is always at T+1.
- WaitCycles = 0 with the macro defined behaves identically to the undefined case.

## Test plan
- Reset, then a read at address 0x0 -> gnt the same cycle; rvalid next cycle with rdata = 0x00000000, err = 0.
- Back-to-back writes, macro off:
  - Write 0xDEADBEEF to 0x10, be = 4'b1111.
  - Next cycle write 0x000000AA to 0x10, be = 4'b0001.
  - Read 0x10 -> 0xDEADBEAA.
  - Expect three consecutive gnt cycles and three consecutive rvalid pulses, each one cycle later.
- Error responses:
  - Read 0x202 (misaligned) -> rvalid with err = 1, rdata = 0.
  - Write to 0x200 (= Depth*4, out of range) -> err = 1; a following read of 0x0 shows the array unchanged.
- Macro on, WaitCycles = 2:
  - Read granted at T -> rvalid at T+3.
  - req held high -> gnt low at T+1 and T+2, high again at T+3, in the same cycle as rvalid.
- Assert rst_ni low one cycle after granting a read of a word holding 0x12345678 -> no rvalid afterwards; a subsequent read returns 0.
- Stream 4 writes then 4 reads to 0x0, 0x4, 0x8, 0xC with data 1..4 -> reads return 1, 2, 3, 4 in order, with exactly 8 rvalid pulses.

Source files
------------

// File: rtl/vcve2_vrf_mem_responder.sv
// vcve2_vrf_mem_responder: VRF data-port memory responder (fixed latency; VCVE2_VRF_RESP_WAIT_EN adds WaitCycles wait states)
module vcve2_vrf_mem_responder #(
  parameter int VLEN       = 128,
  parameter int NumVregs   = 32,
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 32,
  parameter int WaitCycles = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 data_req_i,
  output logic                 data_gnt_o,
  input  logic                 data_we_i,
  input  logic [3:0]           data_be_i,
  input  logic [AddrWidth-1:0] data_addr_i,
  input  logic [31:0]          data_wdata_i,
  output logic                 data_rvalid_o,
  output logic [31:0]          data_rdata_o,
  output logic                 data_err_o
);
  localparam int Depth = NumVregs * VLEN / DataWidth;
  localparam int IdxW = $clog2(Depth);
`ifdef VCVE2_VRF_RESP_WAIT_EN
  localparam int CntW = WaitCycles > 0 ? $clog2(WaitCycles + 1) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  logic [CntW-1:0] cnt;
`else
  localparam int unused_wait_cycles = WaitCycles;
  typedef enum logic {IDLE, RESP} state_e;
`endif
  state_e state;
  logic [31:0] mem [Depth];
  logic [IdxW-1:0] idx;
  logic addr_err;
  assign idx = data_addr_i[2 +: IdxW];
  assign addr_err = (|data_addr_i[1:0]) || (data_addr_i >= AddrWidth'(Depth * 4));
`ifdef VCVE2_VRF_RESP_WAIT_EN
  assign data_gnt_o = data_req_i && rst_ni && (state != WAIT);
`else
  assign data_gnt_o = data_req_i && rst_ni;
`endif
  assign data_rvalid_o = state == RESP;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      data_rdata_o <= '0;
      data_err_o <= 1'b0;
`ifdef VCVE2_VRF_RESP_WAIT_EN
      cnt <= '0;
`endif
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else begin
      if (data_gnt_o) begin
        data_rdata_o <= (data_we_i || addr_err) ? '0 : mem[idx];
        data_err_o <= addr_err;
        if (data_we_i && !addr_err)
          for (int b = 0; b < 4; b++)
            if (data_be_i[b]) mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
`ifdef VCVE2_VRF_RESP_WAIT_EN
        state <= WaitCycles > 0 ? WAIT : RESP;
        cnt <= WaitCycles > 0 ? CntW'(WaitCycles - 1) : '0;
      end else if (state == WAIT) begin
        state <= cnt == '0 ? RESP : WAIT;
        cnt <= cnt == '0 ? cnt : cnt - CntW'(1);
`else
        state <= RESP;
`endif
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule
